// File: rtl/hpm_counter_core.sv
// Hardware performance-monitor core: N_CH event counters with probe select,
// level/edge counting, snapshot/preload, sticky overflow and interrupt.
module hpm_counter_core #(
  parameter int N_CH  = 4,
  parameter int N_EVT = 3,
  parameter int CNT_W = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cs,
  input  logic             write,
  input  logic             read,
  input  logic [4:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  input  logic [N_EVT-1:0] evt,
  output logic             irq
);

  localparam int HI_W = CNT_W - 32;

  logic             run_q, run_d;
  logic             irq_en_q, irq_en_d;
  logic [5:0]       cfg_q  [N_CH];
  logic [5:0]       cfg_d  [N_CH];
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] cnt_d  [N_CH];
  logic [CNT_W-1:0] snap_q [N_CH];
  logic [CNT_W-1:0] snap_d [N_CH];
  logic [N_CH-1:0]  ovf_q, ovf_d, ovf_set;
  logic [N_EVT-1:0] evt_prev_q, evt_prev_d;
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [1:0]       grp;
  logic [2:0]       ch_idx;
  logic             ctrl_wr, status_wr, cfg_wr, lo_wr, hi_wr;
  logic             clear_p, snap_p, load_p, run_eff;
  logic [7:0]       evt_pad, prev_pad;
  logic [N_CH-1:0]  hit;
  logic             unused_rd_strobe;

  // Reads have no side effects, so the read strobe is not needed.
  assign unused_rd_strobe = read;

  always_comb begin
    wr_en     = cs & write;
    grp       = addr[4:3];
    ch_idx    = addr[2:0];
    ctrl_wr   = wr_en & (addr == 5'd0);
    status_wr = wr_en & (addr == 5'd1);
    cfg_wr    = wr_en & (grp == 2'd1);
    lo_wr     = wr_en & (grp == 2'd2);
    hi_wr     = wr_en & (grp == 2'd3);
    clear_p   = ctrl_wr & wr_data[1];
    snap_p    = ctrl_wr & wr_data[2];
    load_p    = ctrl_wr & wr_data[3];
    // A CTRL write takes effect on the run gate in the same edge.
    run_eff   = ctrl_wr ? wr_data[0] : run_q;
    run_d     = ctrl_wr ? wr_data[0] : run_q;
    irq_en_d  = ctrl_wr ? wr_data[8] : irq_en_q;
  end

  // Zero-padding to 8 probes makes out-of-range selects read as no hit.
  always_comb begin
    evt_pad  = 8'(evt);
    prev_pad = 8'(evt_prev_q);
    hit      = '0;
    for (int c = 0; c < N_CH; c++) begin
      hit[c] = evt_pad[cfg_q[c][2:0]] &
               (~cfg_q[c][4] | ~prev_pad[cfg_q[c][2:0]]);
    end
  end

  always_comb begin
    ovf_set = '0;
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c]  = cnt_q[c];
      snap_d[c] = snap_q[c];
      cfg_d[c]  = cfg_q[c];

      if (clear_p) begin
        cnt_d[c] = '0;
      end else if (load_p) begin
        cnt_d[c] = snap_q[c];
      end else if (run_eff & cfg_q[c][5] & hit[c]) begin
        cnt_d[c]   = cnt_q[c] + CNT_W'(1);
        ovf_set[c] = &cnt_q[c];
      end

      // Snapshot takes the pre-edge count, which gives the load/snap swap.
      if (snap_p) begin
        snap_d[c] = cnt_q[c];
      end else if (lo_wr && (int'(ch_idx) == c)) begin
        snap_d[c][31:0] = wr_data;
      end else if (hi_wr && (int'(ch_idx) == c)) begin
        snap_d[c][CNT_W-1:32] = wr_data[HI_W-1:0];
      end

      if (cfg_wr && (int'(ch_idx) == c)) begin
        cfg_d[c] = wr_data[5:0];
      end
    end
  end

  always_comb begin
    ovf_d      = (ovf_q & ~(status_wr ? wr_data[N_CH-1:0] : {N_CH{1'b0}})) | ovf_set;
    irq_d      = |(ovf_q & {N_CH{irq_en_q}});
    evt_prev_d = evt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= '0;
      evt_prev_q <= '0;
      irq_q      <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        cfg_q[c]  <= '0;
        cnt_q[c]  <= '0;
        snap_q[c] <= '0;
      end
    end else begin
      run_q      <= run_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      evt_prev_q <= evt_prev_d;
      irq_q      <= irq_d;
      for (int c = 0; c < N_CH; c++) begin
        cfg_q[c]  <= cfg_d[c];
        cnt_q[c]  <= cnt_d[c];
        snap_q[c] <= snap_d[c];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (grp)
      2'd0: begin
        if (ch_idx == 3'd0) begin
          rd_data = {23'b0, irq_en_q, 7'b0, run_q};
        end else if (ch_idx == 3'd1) begin
          rd_data = 32'(ovf_q);
        end
      end
      2'd1: begin
        for (int c = 0; c < N_CH; c++) begin
          if (int'(ch_idx) == c) rd_data = 32'(cfg_q[c]);
        end
      end
      2'd2: begin
        for (int c = 0; c < N_CH; c++) begin
          if (int'(ch_idx) == c) rd_data = snap_q[c][31:0];
        end
      end
      default: begin
        for (int c = 0; c < N_CH; c++) begin
          if (int'(ch_idx) == c) rd_data = 32'(snap_q[c][CNT_W-1:32]);
        end
      end
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_hpm_counter_core.sv
// Directed bench for hpm_counter_core: expected values go into a scoreboard
// queue as each check is issued and are popped when the DUT output is sampled.
module tb_hpm_counter_core;

  logic        clk;
  logic        reset_n;
  logic        cs;
  logic        write;
  logic        read;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [2:0]  evt;
  logic        irq;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  hpm_counter_core #(.N_CH(4), .N_EVT(3), .CNT_W(48)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .write   (write),
    .read    (read),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .evt     (evt),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic compare_front(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed 0x%08h expected none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
    end
  endtask

  task automatic rd_check(input logic [4:0] a, input logic [31:0] exp, input string tag);
    push_exp(tag, exp);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    compare_front(rd_data);
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic irq_check(input logic exp, input string tag);
    push_exp(tag, {31'b0, exp});
    #1;
    compare_front({31'b0, irq});
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0;
    addr = '0; wr_data = '0; evt = '0;
    repeat (3) tick();
    reset_n = 1'b1;

    rd_check(5'd0,  32'h0, "rst_ctrl");
    rd_check(5'd1,  32'h0, "rst_status");
    rd_check(5'd8,  32'h0, "rst_cfg0");
    rd_check(5'd16, 32'h0, "rst_snap_lo0");
    irq_check(1'b0, "rst_irq");
    tick();

    // level count on ch0
    bus_wr(5'd8, 32'h20);
    bus_wr(5'd0, 32'h1);
    rd_check(5'd0, 32'h1, "ctrl_run");
    evt[0] = 1'b1;
    repeat (10) tick();
    evt[0] = 1'b0;
    bus_wr(5'd0, 32'h0);
    bus_wr(5'd0, 32'h4);
    rd_check(5'd0,  32'h0,  "ctrl_pulses_read0");
    rd_check(5'd16, 32'd10, "lvl_snap_lo0");
    rd_check(5'd24, 32'h0,  "lvl_snap_hi0");
    rd_check(5'd8,  32'h20, "cfg0_readback");
    tick();

    // edge count on ch1, probe already high across the run write
    bus_wr(5'd9, 32'h31);
    evt[1] = 1'b1;
    tick();
    bus_wr(5'd0, 32'h1);
    evt[1] = 1'b0;
    tick();
    for (int p = 0; p < 5; p++) begin
      evt[1] = 1'b1;
      repeat (3) tick();
      evt[1] = 1'b0;
      repeat (3) tick();
    end
    bus_wr(5'd0, 32'h4);
    rd_check(5'd17, 32'd5,  "edge_snap_lo1");
    rd_check(5'd16, 32'd10, "edge_ch0_held");
    tick();

    // wrap and overflow on ch2, irq latency
    bus_wr(5'd10, 32'h22);
    bus_wr(5'd26, 32'hABCD_FFFF);
    rd_check(5'd26, 32'h0000_FFFF, "snap_hi_trunc");
    bus_wr(5'd18, 32'hFFFF_FFFE);
    rd_check(5'd18, 32'hFFFF_FFFE, "snap_lo2_rb");
    bus_wr(5'd0, 32'h8);
    bus_wr(5'd0, 32'h101);
    rd_check(5'd0, 32'h101, "ctrl_irq_en");
    evt[2] = 1'b1;
    tick();
    tick();
    irq_check(1'b0, "irq_not_yet");
    rd_check(5'd1, 32'h4, "ovf_set");
    tick();
    irq_check(1'b1, "irq_latency");
    evt[2] = 1'b0;
    bus_wr(5'd0, 32'h104);
    rd_check(5'd18, 32'd1, "wrap_snap_lo2");
    rd_check(5'd26, 32'h0, "wrap_snap_hi2");
    bus_wr(5'd1, 32'h4);
    rd_check(5'd1, 32'h0, "w1c_status");
    irq_check(1'b1, "irq_one_more");
    tick();
    irq_check(1'b0, "irq_cleared");

    // overflow set wins over a same-cycle W1C; load beats increment
    bus_wr(5'd18, 32'hFFFF_FFFF);
    bus_wr(5'd26, 32'h0000_FFFF);
    bus_wr(5'd0, 32'h108);
    bus_wr(5'd0, 32'h101);
    evt[2] = 1'b1;
    tick();
    bus_wr(5'd0, 32'h109);
    bus_wr(5'd1, 32'h4);
    evt[2] = 1'b0;
    rd_check(5'd1, 32'h4, "ovf_set_wins");
    bus_wr(5'd0, 32'h100);
    bus_wr(5'd1, 32'h4);
    rd_check(5'd1, 32'h0, "w1c_again");
    tick();
    irq_check(1'b0, "irq_after_w1c");

    // clear|snap|run in one write
    bus_wr(5'd0, 32'h2);
    evt[0] = 1'b1;
    bus_wr(5'd0, 32'h1);
    repeat (6) tick();
    bus_wr(5'd0, 32'h7);
    rd_check(5'd16, 32'd7, "prio_snap_pre_clear");
    repeat (4) tick();
    bus_wr(5'd0, 32'h4);
    evt[0] = 1'b0;
    rd_check(5'd16, 32'd4, "prio_count_after");

    // load|snap swap
    bus_wr(5'd0, 32'h2);
    rd_check(5'd16, 32'd4, "clear_keeps_snap");
    bus_wr(5'd16, 32'd100);
    bus_wr(5'd24, 32'd0);
    evt[0] = 1'b1;
    bus_wr(5'd0, 32'h1);
    repeat (19) tick();
    bus_wr(5'd0, 32'hD);
    rd_check(5'd16, 32'd20, "swap_snap_old_cnt");
    repeat (5) tick();
    bus_wr(5'd0, 32'h4);
    evt[0] = 1'b0;
    rd_check(5'd16, 32'd105, "swap_cnt_from_snap");
    tick();

    // reset mid-count
    bus_wr(5'd11, 32'h27);
    evt = 3'b111;
    bus_wr(5'd0, 32'h101);
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    rd_check(5'd0,  32'h0, "midrst_ctrl");
    rd_check(5'd1,  32'h0, "midrst_status");
    rd_check(5'd8,  32'h0, "midrst_cfg0");
    rd_check(5'd16, 32'h0, "midrst_snap_lo0");
    rd_check(5'd26, 32'h0, "midrst_snap_hi2");
    rd_check(5'd11, 32'h0, "midrst_cfg3");
    irq_check(1'b0, "midrst_irq");
    repeat (3) tick();
    bus_wr(5'd0, 32'h4);
    rd_check(5'd16, 32'h0, "midrst_no_count");

    // out-of-range probe select vs a valid one
    bus_wr(5'd11, 32'h27);
    bus_wr(5'd8, 32'h22);
    bus_wr(5'd0, 32'h1);
    repeat (4) tick();
    bus_wr(5'd0, 32'h4);
    rd_check(5'd19, 32'h0, "sel_out_of_range");
    rd_check(5'd16, 32'd5, "post_rst_count");
    evt = 3'b000;
    tick();

    // unimplemented channel and unlisted addresses
    bus_wr(5'd13, 32'h3F);
    rd_check(5'd13, 32'h0, "cfg5_absent");
    rd_check(5'd2,  32'h0, "addr2_unlisted");
    rd_check(5'd31, 32'h0, "snap_hi7_absent");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hpm_counter_core.md
Name: hpm_counter_core

Overview:
Parametrised hardware performance-monitor core, successor to the fixed three-probe counter in the vanilla MMIO subsystem. Provides N_CH independent CNT_W-bit event counters. Each counter selects any of N_EVT probe inputs and counts in level or rising-edge mode, with snapshot/preload, sticky overflow and an interrupt. Sits in one FPro MMIO slot; the probes come from the MCS IO-bus strobes or other fabric events.

Parameters:
N_CH, 4, number of counter channels (1..8)
N_EVT, 3, number of event probe inputs (1..8)
CNT_W, 48, counter width in bits (33..64)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
cs  in  1  slot chip select
write  in  1  write strobe, qualified by cs
read  in  1  read strobe, qualified by cs; no side effects
addr  in  5  word address within slot
wr_data  in  32  write data
rd_data  out  32  read data, combinational from addr
evt  in  N_EVT  event probes, synchronous to clk
irq  out  1  registered interrupt: |(ovf & {N_CH{irq_en}})

Behaviour:
- Register map (word addr):
  - 0 CTRL: b0 run (R/W), b1 clear (pulse, reads 0), b2 snap (pulse, reads 0), b3 load (pulse, reads 0), b8 irq_en (R/W).
  - 1 STATUS: ovf[N_CH-1:0]; write-1-to-clear.
  - 8+c CFG[c]: b2:0 evt_sel, b4 mode (0=level, 1=rising edge), b5 en.
  - 16+c SNAP_LO[c]: snapshot bits 31:0, R/W.
  - 24+c SNAP_HI[c]: snapshot bits CNT_W-1:32, zero-extended on read; upper write bits ignored.
  - Channels c>=N_CH and unlisted addresses read 0; writes to them are ignored.
- Reset (reset_n=0 at an edge): counters, snapshots, CFG, CTRL, ovf, evt_prev and irq all go to 0.
- evt_prev <= evt every cycle, independent of run.
- Increment condition for channel c in cycle t: run & en & hit.
  - Level mode: hit = evt[sel].
  - Edge mode: hit = evt[sel] & ~evt_prev[sel].
  - Counter holds the incremented value after the edge ending cycle t.
  - evt_sel >= N_EVT: hit = 0.
- Wrap-around: counter at 2^CNT_W-1 that increments becomes 0 and sets ovf[c] on the same edge.
- Counter update priority per edge: clear (-> 0) > load (<= snap[c]) > increment > hold.
- snap pulse: every snap[c] <= current counter value (pre-edge). Increments in that cycle are excluded.
- Simultaneous pulses:
  - snap+clear: snap captures the pre-clear value.
  - snap+load: counter and snapshot swap old values.
- ovf sticky. Set and W1C in the same cycle: set wins. clear does not touch ovf or snapshots.
- CTRL write with run=0 freezes all counters in the same edge. The register bus works regardless of run.
- irq: 1-cycle registered latency from ovf/irq_en change.
- Reset asserted mid-count: all state is 0 after that edge. Events during reset are ignored.

Test Plan:
- Level count: CFG[0]=0x20 (evt 0, level, en); run=1; hold evt[0]=1 for 10 cycles; run=0; snap -> SNAP_LO[0]=10, SNAP_HI[0]=0.
- Edge count: CFG[1]=0x31 (evt 1, edge); 5 pulses of 3 cycles each, plus evt[1] high across the run=1 write; snap -> SNAP_LO[1]=5 (6 if the high level starts after run).
- Wrap/overflow: CNT_W=48; write SNAP_HI[2]=0xFFFF, SNAP_LO[2]=0xFFFFFFFE; load; level count 3 cycles; snap -> SNAP_LO=1, SNAP_HI=0, STATUS=0x4. With irq_en=1, irq=1 one cycle after ovf. W1C 0x4 -> STATUS=0, irq=0.
- Priority: with ch0 counting, one CTRL write sets clear|snap|run -> snap holds pre-clear count (e.g. 7), counter=0, next snap=cycles after.
- Swap: counter=20, snap=100; CTRL write load|snap|run -> next snap reads 100-based count; SNAP_LO immediately after = 20.
- Reset mid-count: assert reset_n=0 for 1 cycle during counting -> all registers read 0, irq=0, no counting until CFG/run are rewritten.
